// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    MWAIT = 2'd3
  } state_t;

  localparam int REG_ZERO = 0;

  // Control word the ID/EX register loads whenever idex_bubble is high.
  localparam logic [7:0] NOP_CTRL = 8'h00;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational load-use comparator for one issue slot
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic [REG_AW-1:0] dest,
  input  logic              mem_read,
  output logic              hit
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  assign dest_live = mem_read && (dest != REG_AW'(REG_ZERO));
  assign rs_match  = uses_rs && (rs == dest);
  assign rt_match  = uses_rt && (rt == dest);
  assign hit       = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - stall/flush/freeze FSM for the 5-stage pipe
// Optional HAZARD_PERF_CNT_EN adds stall/flush/freeze event counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW           = 5,
  parameter int LOAD_USE_CYCLES  = 1,
  parameter int REDIRECT_PENALTY = 1,
  parameter int NSLOT            = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rs,
  input  logic              ifid_uses_rt,
  input  logic [REG_AW-1:0] idex_dest,
  input  logic              idex_mem_read,
  input  logic              redirect,
  input  logic              dmem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_bubble,
  output logic [NSLOT-1:0]  flush,
  output logic              freeze,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events,
  output logic [31:0]       freeze_cycles,
`endif
  output logic [STATE_W-1:0] state_o
);

  if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 7) begin : g_chk_lu
    $error("LOAD_USE_CYCLES must be 1..7");
  end
  if (REDIRECT_PENALTY < 1 || REDIRECT_PENALTY > 7) begin : g_chk_rp
    $error("REDIRECT_PENALTY must be 1..7");
  end
  if (NSLOT < 1 || NSLOT > 7) begin : g_chk_ns
    $error("NSLOT must be 1..7");
  end

  localparam logic [2:0]       LU_RELOAD = 3'(LOAD_USE_CYCLES - 2);
  localparam logic [2:0]       RP_RELOAD = 3'(REDIRECT_PENALTY - 2);
  localparam logic [NSLOT-1:0] FLUSH_ALL = '1;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       pend, pend_nxt;
  logic       hit;
  logic       run_like;
  logic       redir;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .rs       (ifid_rs),
    .rt       (ifid_rt),
    .uses_rs  (ifid_uses_rs),
    .uses_rt  (ifid_uses_rt),
    .dest     (idex_dest),
    .mem_read (idex_mem_read),
    .hit      (hit)
  );

  // A memory wait ending behaves as a RUN cycle; a redirect seen while
  // frozen is replayed on that exit cycle.
  assign run_like = (state == RUN) || (state == MWAIT && !dmem_busy);
  assign redir    = redirect || (state == MWAIT && pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    flush       = '0;
    freeze      = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
    end else if (run_like) begin
      pend_nxt = 1'b0;
      if (redir) begin
        flush = FLUSH_ALL;
        if (REDIRECT_PENALTY > 1) begin
          cnt_nxt   = RP_RELOAD;
          state_nxt = FLUSH;
        end else begin
          state_nxt = RUN;
        end
      end else if (dmem_busy) begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        freeze    = 1'b1;
        state_nxt = MWAIT;
      end else if (hit) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          cnt_nxt   = LU_RELOAD;
          state_nxt = STALL;
        end else begin
          state_nxt = RUN;
        end
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        STALL: begin
          if (redirect) begin
            flush = FLUSH_ALL;
            if (REDIRECT_PENALTY > 1) begin
              cnt_nxt   = RP_RELOAD;
              state_nxt = FLUSH;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            if (dmem_busy) begin
              freeze = 1'b1;
            end else begin
              idex_bubble = 1'b1;
              if (cnt == 3'd0) state_nxt = RUN;
              else             cnt_nxt   = cnt - 3'd1;
            end
          end
        end
        FLUSH: begin
          flush[0] = 1'b1;
          if (redirect) begin
            flush   = FLUSH_ALL;
            cnt_nxt = RP_RELOAD;
          end else begin
            if (dmem_busy) begin
              freeze = 1'b1;
              pc_we  = 1'b0;
            end
            if (cnt == 3'd0) state_nxt = RUN;
            else             cnt_nxt   = cnt - 3'd1;
          end
        end
        MWAIT: begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          freeze  = 1'b1;
          if (redirect) begin
            flush    = FLUSH_ALL;
            pend_nxt = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      flush_events  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (idex_bubble && stall_cycles != '1)  stall_cycles  <= stall_cycles + 32'd1;
      if (redirect && flush_events != '1)     flush_events  <= flush_events + 32'd1;
      if (freeze && freeze_cycles != '1)      freeze_cycles <= freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       mr;
    logic       red;
    logic       busy;
    logic       rn;
  } in_t;

  typedef struct {
    int         d;
    string      name;
    logic       pc;
    logic       ifid;
    logic       bub;
    logic [1:0] fl;
    logic       frz;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] ifid_rs = 5'd1, ifid_rt = 5'd2, idex_dest = 5'd3;
  logic       ifid_uses_rs = 1'b1, ifid_uses_rt = 1'b1;
  logic       idex_mem_read = 1'b0, redirect = 1'b0, dmem_busy = 1'b0;

  logic       pc_we_w [3];
  logic       ifid_we_w [3];
  logic       bub_w [3];
  logic [1:0] flush_w [3];
  logic       freeze_w [3];
  logic [1:0] st_w [3];

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Instance 0: LUC=1 RP=3; instance 1: LUC=3 RP=1; instance 2: LUC=2 RP=1.
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(1), .REDIRECT_PENALTY(3), .NSLOT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .idex_dest(idex_dest),
    .idex_mem_read(idex_mem_read), .redirect(redirect), .dmem_busy(dmem_busy),
    .pc_we(pc_we_w[0]), .ifid_we(ifid_we_w[0]), .idex_bubble(bub_w[0]),
    .flush(flush_w[0]), .freeze(freeze_w[0]), .state_o(st_w[0]));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(3), .REDIRECT_PENALTY(1), .NSLOT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .idex_dest(idex_dest),
    .idex_mem_read(idex_mem_read), .redirect(redirect), .dmem_busy(dmem_busy),
    .pc_we(pc_we_w[1]), .ifid_we(ifid_we_w[1]), .idex_bubble(bub_w[1]),
    .flush(flush_w[1]), .freeze(freeze_w[1]), .state_o(st_w[1]));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_CYCLES(2), .REDIRECT_PENALTY(1), .NSLOT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt), .idex_dest(idex_dest),
    .idex_mem_read(idex_mem_read), .redirect(redirect), .dmem_busy(dmem_busy),
    .pc_we(pc_we_w[2]), .ifid_we(ifid_we_w[2]), .idex_bubble(bub_w[2]),
    .flush(flush_w[2]), .freeze(freeze_w[2]), .state_o(st_w[2]));

  function automatic in_t mk(bit hit, bit red, bit busy, bit rn);
    in_t v;
    v.rs = 5'd1; v.rt = 5'd2; v.urs = 1'b1; v.urt = 1'b1;
    v.dest = 5'd3; v.mr = 1'b0; v.red = red; v.busy = busy; v.rn = rn;
    if (hit) begin
      v.rs = 5'd8; v.dest = 5'd8; v.mr = 1'b1;
    end
    return v;
  endfunction

  task automatic cyc(input int d, input string name, input in_t v,
                     input logic pc, input logic ifid, input logic bub,
                     input logic [1:0] fl, input logic frz, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rs = v.urs; ifid_uses_rt = v.urt;
    idex_dest = v.dest; idex_mem_read = v.mr; redirect = v.red;
    dmem_busy = v.busy; rst_n = v.rn;
    e.d = d; e.name = name; e.pc = pc; e.ifid = ifid; e.bub = bub;
    e.fl = fl; e.frz = frz; e.st = st;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (pc_we_w[e.d] !== e.pc || ifid_we_w[e.d] !== e.ifid || bub_w[e.d] !== e.bub ||
          flush_w[e.d] !== e.fl || freeze_w[e.d] !== e.frz || st_w[e.d] !== e.st) begin
        miscompares++;
        $display("FAIL %s dut%0d: got pc=%b ifid=%b bub=%b flush=%b frz=%b st=%0d want pc=%b ifid=%b bub=%b flush=%b frz=%b st=%0d",
                 e.name, e.d, pc_we_w[e.d], ifid_we_w[e.d], bub_w[e.d], flush_w[e.d],
                 freeze_w[e.d], st_w[e.d], e.pc, e.ifid, e.bub, e.fl, e.frz, e.st);
      end
    end
  end

  initial begin
    in_t v;
    // Reset with a live hazard on the inputs: outputs must still be reset values.
    cyc(0, "rst_a", mk(1, 0, 0, 0), 1, 1, 0, 2'b00, 0, 2'd0);
    cyc(1, "rst_b", mk(1, 1, 1, 0), 1, 1, 0, 2'b00, 0, 2'd0);
    cyc(0, "idle_a", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Single-cycle load-use stall.
    cyc(0, "lu1_hit", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd0);
    cyc(0, "lu1_after", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // $0 and unused-field exclusions.
    v = mk(0, 0, 0, 1); v.rs = 5'd0; v.dest = 5'd0; v.mr = 1'b1;
    cyc(0, "zero_reg", v, 1, 1, 0, 2'b00, 0, 2'd0);
    v = mk(0, 0, 0, 1); v.rt = 5'd8; v.dest = 5'd8; v.mr = 1'b1; v.urt = 1'b0;
    cyc(0, "unused_rt", v, 1, 1, 0, 2'b00, 0, 2'd0);
    v.urt = 1'b1;
    cyc(0, "used_rt", v, 0, 0, 1, 2'b00, 0, 2'd0);

    // Redirect with penalty 3.
    cyc(0, "rp3_c0", mk(0, 1, 0, 1), 1, 1, 0, 2'b11, 0, 2'd0);
    cyc(0, "rp3_c1", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "rp3_c2", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "rp3_done", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Reset asserted mid-flush.
    cyc(0, "rf_red", mk(0, 1, 0, 1), 1, 1, 0, 2'b11, 0, 2'd0);
    cyc(0, "rf_flush", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "rf_rst", mk(0, 0, 0, 0), 1, 1, 0, 2'b00, 0, 2'd0);
    cyc(0, "rf_rel0", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);
    cyc(0, "rf_rel1", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Three-cycle stall abandoned by a redirect.
    cyc(1, "lu3_c0", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd0);
    cyc(1, "lu3_c1", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd1);
    cyc(1, "lu3_red", mk(1, 1, 0, 1), 1, 1, 0, 2'b11, 0, 2'd1);
    cyc(1, "lu3_after", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Memory busy for 4 cycles inside a two-cycle stall.
    cyc(2, "lu2_hit", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd0);
    for (int i = 0; i < 4; i++)
      cyc(2, "lu2_busy", mk(1, 0, 1, 1), 0, 0, 0, 2'b00, 1, 2'd1);
    cyc(2, "lu2_rest", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd1);
    cyc(2, "lu2_done", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Redirect captured while frozen, replayed through FLUSH on exit.
    cyc(0, "mw_enter", mk(0, 0, 1, 1), 0, 0, 0, 2'b00, 1, 2'd0);
    cyc(0, "mw_red", mk(0, 1, 1, 1), 0, 0, 0, 2'b11, 1, 2'd3);
    cyc(0, "mw_hold", mk(0, 0, 1, 1), 0, 0, 0, 2'b00, 1, 2'd3);
    cyc(0, "mw_exit", mk(0, 0, 0, 1), 1, 1, 0, 2'b11, 0, 2'd3);
    cyc(0, "mw_fl1", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "mw_fl2", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "mw_run", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Hit re-evaluated on the cycle the memory wait ends.
    cyc(2, "mh_busy", mk(0, 0, 1, 1), 0, 0, 0, 2'b00, 1, 2'd0);
    cyc(2, "mh_exit", mk(1, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd3);
    cyc(2, "mh_stall", mk(0, 0, 0, 1), 0, 0, 1, 2'b00, 0, 2'd1);
    cyc(2, "mh_run", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    // Memory busy during FLUSH: fetch-side counter keeps running.
    cyc(0, "fb_red", mk(0, 1, 0, 1), 1, 1, 0, 2'b11, 0, 2'd0);
    cyc(0, "fb_busy", mk(0, 0, 1, 1), 0, 1, 0, 2'b01, 1, 2'd2);
    cyc(0, "fb_last", mk(0, 0, 0, 1), 1, 1, 0, 2'b01, 0, 2'd2);
    cyc(0, "fb_run", mk(0, 0, 0, 1), 1, 1, 0, 2'b00, 0, 2'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It replaces single-cycle load-use detection with a registered FSM that covers:
- multi-cycle load-use stalls;
- branch/jump/jr redirect flushes with configurable refetch penalty;
- whole-pipe freeze while data memory is busy.

It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush controls.

Parameters:
REG_AW, 5, register-address width
LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
REDIRECT_PENALTY, 1, cycles IF/ID is flushed per redirect (1..7)
NSLOT, 2, younger pipeline registers flushed on redirect (bit0=IF/ID, bit1=ID/EX, ...)

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
ifid_rs  in  REG_AW  rs field of instruction in IF/ID
ifid_rt  in  REG_AW  rt field of instruction in IF/ID
ifid_uses_rs  in  1  IF/ID instruction reads rs
ifid_uses_rt  in  1  IF/ID instruction reads rt
idex_dest  in  REG_AW  destination register of ID/EX instruction
idex_mem_read  in  1  ID/EX instruction is a load
redirect  in  1  taken branch / jump / jr resolved this cycle
dmem_busy  in  1  data memory not ready; pipe must freeze
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
idex_bubble  out  1  load ID/EX with NOP control word
flush  out  NSLOT  per-stage flush (clears valid/control)
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; counter=0.
  - Outputs while reset is asserted: pc_we=1, ifid_we=1, idex_bubble=0, flush=0, freeze=0.
  - Reset asserted mid-stall or mid-flush aborts immediately; no residual bubbles after release.
- Hazard detect (combinational): hit = idex_mem_read & (idex_dest!=0) & ((ifid_uses_rs & ifid_rs==idex_dest) | (ifid_uses_rt & ifid_rt==idex_dest)).
  - Register $0 never causes a stall.
  - An unused source field never causes a stall.
- States: RUN(0), STALL(1), FLUSH(2), MWAIT(3). 3-bit down-counter cnt.
- Outputs are combinational from state plus inputs, so they act in the same cycle as the event.
- Priority in every state: redirect > dmem_busy > hit.
- RUN:
  - redirect: flush=all ones, pc_we=1, ifid_we=1.
    - If REDIRECT_PENALTY>1: cnt=REDIRECT_PENALTY-2, go FLUSH. Otherwise stay in RUN.
  - dmem_busy: pc_we=0, ifid_we=0, freeze=1, go MWAIT.
  - hit: pc_we=0, ifid_we=0, idex_bubble=1.
    - If LOAD_USE_CYCLES>1: cnt=LOAD_USE_CYCLES-2, go STALL. Otherwise stay in RUN.
  - none of the above: pc_we=ifid_we=1, other outputs 0.
- STALL:
  - Outputs: pc_we=0, ifid_we=0, idex_bubble=1.
  - cnt==0: go RUN. Otherwise cnt decrements.
  - redirect: behave as RUN redirect; cnt is reloaded and the remaining stall is abandoned.
  - dmem_busy: freeze overrides the bubble (idex_bubble=0), cnt holds, state unchanged.
- FLUSH:
  - Outputs: flush[0]=1, pc_we=1, ifid_we=1.
  - cnt==0: go RUN. Otherwise cnt decrements.
  - A new redirect reloads cnt (the penalty restarts).
  - dmem_busy: freeze=1 and pc_we=0; cnt still decrements (fetch side is independent).
- MWAIT:
  - Outputs: pc_we=0, ifid_we=0, freeze=1, no bubble.
  - Exit to RUN on the first cycle with dmem_busy=0; hit is re-evaluated in that RUN cycle.
  - redirect while busy: flush is asserted and recorded as a pending flag; the flush is applied on exit through the FLUSH path.
- No arithmetic beyond the 3-bit counter.
- Elaboration guard: parameters of 0 or above 7 trigger $error.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs stall_cycles[31:0], flush_events[31:0] and freeze_cycles[31:0].
  - Each is a saturating counter, cleared only by rst_n.
  - Each increments once per cycle with idex_bubble=1, once per redirect, and once per cycle with freeze=1, respectively.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN/STALL/FLUSH/MWAIT) and its 2-bit width;
  - REG_ZERO constant;
  - NOP control-word constant used alongside idex_bubble.
- One sub-module: hazard_cmp, the combinational load-use comparator producing hit. It is reusable later for a second issue slot.

Test Plan:
- Load-use hazard, LOAD_USE_CYCLES=1: idex_mem_read=1, idex_dest=8, ifid_rs=8, uses_rs=1 -> exactly 1 cycle with pc_we=0 and idex_bubble=1; then RUN.
- $0 and unused-field exclusion: idex_dest=0 with a matching rs, and a separate case with ifid_rt match but uses_rt=0 -> no stall.
- LOAD_USE_CYCLES=3 with redirect in the 2nd stall cycle -> flush=2'b11 in that cycle and stall abandoned; total bubbles=2.
- REDIRECT_PENALTY=3, single redirect pulse -> flush=11 then 01, 01 over 3 consecutive cycles; back to RUN.
- dmem_busy held 4 cycles during STALL (LOAD_USE_CYCLES=2) -> freeze=1 for 4 cycles, cnt held, 1 remaining bubble after release.
- rst_n low mid-FLUSH -> outputs return immediately to their reset values; state_o=0 after release.
